// File: rtl/coin_acceptor.sv
// Coin sensor front end: synchronises and debounces the two coin sensors, then emits accept/reject pulses and a saturating credit total.
// Define COIN_JAM_DETECT_EN to build the jam counter and the JAM state; otherwise jam is held at 0.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int JAM_CYCLES      = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin1_raw,
    input  logic       coin2_raw,
    input  logic       accept_en,
    input  logic       credit_clr,
    output logic       coin_1,
    output logic       coin_2,
    output logic       coin_reject,
    output logic       jam,
    output logic [7:0] credit_total
);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_DEBOUNCE     = 2'd1,
        ST_WAIT_RELEASE = 2'd2,
        ST_JAM          = 2'd3
    } state_t;

    localparam logic [3:0]  DB_LAST = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] JAM_LIM = 16'(JAM_CYCLES);

    function automatic logic [7:0] credit_add(input logic [7:0] base, input logic [1:0] val);
        logic [8:0] sum;
        sum = {1'b0, base} + {7'd0, val};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    logic       c1_meta_q, c2_meta_q;
    logic       s1_q, s2_q;
    state_t     state_q;
    logic [3:0] cnt_q;
    logic       sel_q;
    logic       coin1_q, coin2_q, reject_q, jam_q;
    logic [7:0] credit_q;

    logic any_s, both_s, latched_s, other_s, jam_hit_s;

    assign any_s     = s1_q | s2_q;
    assign both_s    = s1_q & s2_q;
    assign latched_s = sel_q ? s2_q : s1_q;
    assign other_s   = sel_q ? s1_q : s2_q;

    // Two-flop synchronisers for the asynchronous sensor inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c1_meta_q <= 1'b0;
            c2_meta_q <= 1'b0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
        end else begin
            c1_meta_q <= coin1_raw;
            c2_meta_q <= coin2_raw;
            s1_q      <= c1_meta_q;
            s2_q      <= c2_meta_q;
        end
    end

`ifdef COIN_JAM_DETECT_EN
    logic [15:0] jam_cnt_q;

    assign jam_hit_s = any_s && (jam_cnt_q == JAM_LIM - 16'd1);

    // Counts consecutive sensor-high cycles while a coin is being handled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            jam_cnt_q <= 16'd0;
        end else if (any_s && (state_q == ST_DEBOUNCE || state_q == ST_WAIT_RELEASE)) begin
            jam_cnt_q <= jam_cnt_q + 16'd1;
        end else begin
            jam_cnt_q <= 16'd0;
        end
    end
`else
    logic [15:0] unused_jam_lim;

    assign unused_jam_lim = JAM_LIM;
    assign jam_hit_s      = 1'b0;
`endif

    // Main FSM with registered pulses, jam level and credit total.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            sel_q    <= 1'b0;
            coin1_q  <= 1'b0;
            coin2_q  <= 1'b0;
            reject_q <= 1'b0;
            jam_q    <= 1'b0;
            credit_q <= 8'd0;
        end else begin
            coin1_q  <= 1'b0;
            coin2_q  <= 1'b0;
            reject_q <= 1'b0;
            // An accept below overrides this clear with the coin value added to 0.
            if (credit_clr) begin
                credit_q <= 8'd0;
            end else begin
                credit_q <= credit_q;
            end
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= 4'd0;
                    if (both_s) begin
                        reject_q <= 1'b1;
                        state_q  <= ST_WAIT_RELEASE;
                    end else if (any_s) begin
                        sel_q   <= s2_q;
                        state_q <= ST_DEBOUNCE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (jam_hit_s) begin
                        jam_q   <= 1'b1;
                        cnt_q   <= 4'd0;
                        state_q <= ST_JAM;
                    end else if (other_s) begin
                        reject_q <= 1'b1;
                        cnt_q    <= 4'd0;
                        state_q  <= ST_WAIT_RELEASE;
                    end else if (!latched_s) begin
                        cnt_q   <= 4'd0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == DB_LAST) begin
                        if (accept_en) begin
                            coin1_q  <= ~sel_q;
                            coin2_q  <= sel_q;
                            credit_q <= credit_add(credit_clr ? 8'd0 : credit_q,
                                                   sel_q ? 2'd2 : 2'd1);
                        end else begin
                            reject_q <= 1'b1;
                        end
                        cnt_q   <= 4'd0;
                        state_q <= ST_WAIT_RELEASE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ST_WAIT_RELEASE, ST_JAM: begin
                    if (jam_hit_s && state_q == ST_WAIT_RELEASE) begin
                        jam_q   <= 1'b1;
                        cnt_q   <= 4'd0;
                        state_q <= ST_JAM;
                    end else if (any_s) begin
                        cnt_q <= 4'd0;
                    end else if (cnt_q == DB_LAST) begin
                        jam_q   <= 1'b0;
                        cnt_q   <= 4'd0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: begin
                    cnt_q   <= 4'd0;
                    jam_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign coin_1       = coin1_q;
    assign coin_2       = coin2_q;
    assign coin_reject  = reject_q;
    assign jam          = jam_q;
    assign credit_total = credit_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: vector table of insertions plus latency, saturation, reset and jam sequences.
module tb_coin_acceptor;

    localparam int DB   = 4;
    localparam int JAMC = 40;

    logic       clk = 1'b0;
    logic       rst_n, coin1_raw, coin2_raw, accept_en, credit_clr;
    logic       coin_1, coin_2, coin_reject, jam;
    logic [7:0] credit_total;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt1, cnt2, cntr;
    int excl_viol = 0;

    typedef struct {
        logic c1;
        logic c2;
        logic acc;
        int   hold;
        int   e1;
        int   e2;
        int   erej;
        int   ecredit;
    } vec_t;

    vec_t vecs[7];

    coin_acceptor #(.DEBOUNCE_CYCLES(DB), .JAM_CYCLES(JAMC)) dut (
        .clk(clk), .rst_n(rst_n), .coin1_raw(coin1_raw), .coin2_raw(coin2_raw),
        .accept_en(accept_en), .credit_clr(credit_clr), .coin_1(coin_1),
        .coin_2(coin_2), .coin_reject(coin_reject), .jam(jam),
        .credit_total(credit_total)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cnt1 += int'(coin_1);
        cnt2 += int'(coin_2);
        cntr += int'(coin_reject);
        if (int'(coin_1) + int'(coin_2) + int'(coin_reject) > 1) excl_viol++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_counts();
        cnt1 = 0;
        cnt2 = 0;
        cntr = 0;
    endtask

    initial begin
        int exp_jam;
`ifdef COIN_JAM_DETECT_EN
        exp_jam = 1;
`else
        exp_jam = 0;
`endif
        //            c1    c2    acc   hold e1 e2 rej credit
        vecs[0] = '{1'b1, 1'b0, 1'b1, 10,  1, 0, 0,  1};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 2,   0, 0, 0,  1};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 8,   0, 0, 1,  1};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 10,  0, 0, 1,  1};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 10,  0, 1, 0,  3};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 4,   0, 0, 0,  3};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 5,   1, 0, 0,  4};

        rst_n = 1'b0; coin1_raw = 1'b0; coin2_raw = 1'b0;
        accept_en = 1'b1; credit_clr = 1'b0;
        clear_counts();
        run(3);
        check("reset coin_1", coin_1, 0);
        check("reset coin_2", coin_2, 0);
        check("reset reject", coin_reject, 0);
        check("reset jam", jam, 0);
        check("reset credit", credit_total, 0);
        rst_n = 1'b1;
        run(2);

        for (int i = 0; i < 7; i++) begin
            clear_counts();
            coin1_raw = vecs[i].c1;
            coin2_raw = vecs[i].c2;
            accept_en = vecs[i].acc;
            run(vecs[i].hold);
            coin1_raw = 1'b0;
            coin2_raw = 1'b0;
            run(20);
            check($sformatf("vec%0d coin_1 count", i), cnt1, vecs[i].e1);
            check($sformatf("vec%0d coin_2 count", i), cnt2, vecs[i].e2);
            check($sformatf("vec%0d reject count", i), cntr, vecs[i].erej);
            check($sformatf("vec%0d credit", i), credit_total, vecs[i].ecredit);
        end

        // Exact accept latency: pulse in the cycle after edge E0+6, credit on the same edge.
        clear_counts();
        accept_en = 1'b1;
        coin1_raw = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            check($sformatf("latency coin_1 t%0d", t), coin_1, (t == 7) ? 1 : 0);
            if (t == 6) check("credit before accept", credit_total, 4);
            if (t == 7) check("credit at accept", credit_total, 5);
        end
        coin1_raw = 1'b0;
        run(20);

        // Clear, then saturate with 128 two-rupee coins.
        credit_clr = 1'b1;
        tick();
        credit_clr = 1'b0;
        check("credit after clr", credit_total, 0);
        clear_counts();
        for (int k = 0; k < 128; k++) begin
            coin2_raw = 1'b1;
            run(7);
            coin2_raw = 1'b0;
            run(9);
            if (k == 126) check("credit after 127 coins", credit_total, 254);
        end
        check("credit saturated", credit_total, 255);
        check("saturation coin_2 count", cnt2, 128);

        // credit_clr coincident with a one-rupee accept.
        clear_counts();
        coin1_raw = 1'b1;
        run(6);
        credit_clr = 1'b1;
        tick();
        credit_clr = 1'b0;
        check("clr+accept coin_1", coin_1, 1);
        check("clr+accept credit", credit_total, 1);
        coin1_raw = 1'b0;
        run(20);
        check("clr+accept coin_1 count", cnt1, 1);

        // Reset at E0+4 of a valid insertion.
        clear_counts();
        coin1_raw = 1'b1;
        run(4);
        rst_n = 1'b0;
        tick();
        coin1_raw = 1'b0;
        check("midreset coin_1", coin_1, 0);
        check("midreset credit", credit_total, 0);
        check("midreset jam", jam, 0);
        run(3);
        rst_n = 1'b1;
        run(3);
        check("midreset no pulse", cnt1 + cnt2 + cntr, 0);
        coin1_raw = 1'b1;
        run(10);
        coin1_raw = 1'b0;
        run(20);
        check("post-reset coin_1 count", cnt1, 1);
        check("post-reset credit", credit_total, 1);

        // Long hold: one accept, then jam (when built) and release.
        clear_counts();
        coin1_raw = 1'b1;
        run(60);
        check("jam hold coin_1 count", cnt1, 1);
        check("jam hold reject count", cntr, 0);
        check("jam level during hold", jam, exp_jam);
        coin1_raw = 1'b0;
        run(3);
        check("jam level early release", jam, exp_jam);
        run(7);
        check("jam cleared", jam, 0);
        check("jam credit", credit_total, 2);
        run(5);
        check("jam no extra pulses", cnt1 + cnt2 + cntr, 1);

        check("pulse exclusivity violations", excl_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end coin sensor stage that sits directly upstream of the vending machine FSM. It synchronises and debounces the two raw coin sensors and emits exactly one single-cycle `coin_1` or `coin_2` pulse per valid insertion. Invalid events produce a reject pulse: simultaneous sensors, or coins inserted while acceptance is inhibited. A sensor held high too long is flagged as a jam. The block also keeps a saturating running total of accepted credit.

## Interface
- `DEBOUNCE_CYCLES`, 4, consecutive stable cycles required to accept a coin or a release; legal range 2–15.
- `JAM_CYCLES`, 1000, consecutive cycles with any sensor high before jam is declared; legal range ≥ 2·`DEBOUNCE_CYCLES`, < 2^16.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `coin1_raw` in 1: ₹1 sensor, asynchronous, high while a coin is present.
- `coin2_raw` in 1: ₹2 sensor, asynchronous.
- `accept_en` in 1: 1 = coins accepted; 0 = coins rejected (downstream busy dispensing).
- `credit_clr` in 1: clears `credit_total`.
- `coin_1` out 1: registered single-cycle pulse, ₹1 accepted.
- `coin_2` out 1: registered single-cycle pulse, ₹2 accepted.
- `coin_reject` out 1: registered single-cycle pulse, coin rejected.
- `jam` out 1: registered level, sensor jam active.
- `credit_total` out 8: registered saturating sum of accepted value in ₹.

## Operation
- Each raw input passes through a 2-flop synchroniser. `s1` and `s2` are the synchronised values.
- State machine has four states: IDLE, DEBOUNCE, WAIT_RELEASE, JAM.
- **IDLE**
  - Exactly one of `s1`/`s2` high → DEBOUNCE. Latch which sensor is active; `cnt` = 0.
  - Both high → pulse `coin_reject`, go to WAIT_RELEASE.
  - Neither high → stay.
- **DEBOUNCE**
  - Latched sensor high and other sensor low: `cnt`++.
  - When `cnt` = `DEBOUNCE_CYCLES`−1 and still valid:
    - `accept_en`=1 → pulse `coin_1` or `coin_2` and add 1 or 2 to `credit_total`.
    - `accept_en`=0 → pulse `coin_reject`.
    - Then go to WAIT_RELEASE.
  - Latched sensor drops before acceptance → glitch. Return to IDLE with no output.
  - Other sensor rises before acceptance → pulse `coin_reject`, go to WAIT_RELEASE.
- **WAIT_RELEASE**
  - Requires both sensors low for `DEBOUNCE_CYCLES` consecutive cycles, then go to IDLE. Any high sample restarts the count.
- **JAM**
  - `jam`=1.
  - Exit to IDLE after both sensors are low for `DEBOUNCE_CYCLES` consecutive cycles; `jam` clears on that transition.
  - No coin or reject pulses are produced in JAM.
- **Jam counter**
  - 16-bit counter increments every cycle `s1|s2` is high in DEBOUNCE or WAIT_RELEASE; it clears when both are low.
  - Reaching `JAM_CYCLES` forces JAM from either state.
- **Credit**
  - `credit_total` saturates at 255, with no wrap.
  - `credit_clr` has priority over the existing value. If clr and an accept occur in the same cycle, the result equals the accepted coin value (1 or 2).
- At most one of `coin_1`, `coin_2`, `coin_reject` is high in any cycle.

## Timing
- Reset: state IDLE, synchronisers 0, counters 0. All outputs = 0, including `credit_total`=0 and `jam`=0.
- Reset asserted mid-debounce or in JAM aborts with no pulse on the following cycle.
- Accept latency: raw input first sampled high at edge E0 and held stable. The output pulse is high for exactly the one cycle following edge E0+2+`DEBOUNCE_CYCLES` (E0+6 at default).
- `accept_en` is sampled only on the acceptance edge.
- `credit_total` updates on the same edge the accept pulse asserts.
- Minimum spacing between two accepted coins is 2·`DEBOUNCE_CYCLES`+1 cycles.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no output.

## Configuration
- `COIN_JAM_DETECT_EN` defined:
  - Jam counter and JAM state are built as described.
- `COIN_JAM_DETECT_EN` undefined:
  - No jam counter; JAM is unreachable; `jam` is tied 0.
  - A held sensor remains in WAIT_RELEASE indefinitely with no further pulses.
  - `JAM_CYCLES` is ignored.

## Test plan
- Reset, `accept_en`=1, `coin1_raw` high 10 cycles then low → exactly one `coin_1` pulse at E0+6; `credit_total`=1.
- `coin2_raw` high 2 cycles (glitch) → no pulses; `credit_total` unchanged.
- Both raw inputs high together for 8 cycles → one `coin_reject`, no coin pulse, `credit_total` unchanged.
- `accept_en`=0, valid ₹2 insertion → `coin_reject` only. Then `accept_en`=1 with 128 ₹2 insertions → `credit_total` saturates at 255. `credit_clr` coincident with a ₹1 accept → `credit_total`=1.
- With `COIN_JAM_DETECT_EN`, `JAM_CYCLES`=40: hold `coin1_raw` high 60 cycles → one `coin_1`, then `jam`=1. Release → `jam`=0 after `DEBOUNCE_CYCLES` low cycles. Without the macro → `jam` stays 0.
- Assert `rst_n`=0 at cycle E0+4 of a valid insertion → no pulse, all outputs 0. After release, a new insertion is accepted normally.
